// File: rtl/cr_clk_lpmd_ctrl_if.sv
// Low-power-mode handshake bundle between core, pad and the clock sequencer.
// master: core/pad side; slave: cr_clk_lpmd_ctrl.
interface cr_clk_lpmd_ctrl_if;
  logic       pad_yy_test_mode;
  logic       cp0_clk_lpmd_req;
  logic [1:0] cp0_clk_lpmd_mode;
  logic       core_clk_idle;
  logic       pad_clk_wakeup;
  logic       had_clk_dbg_req;
  logic       clk_core_gate_en;
  logic       clk_cp0_lpmd_ack;
  logic [1:0] clk_pad_lpmd_b;
  logic       clk_cp0_wakeup_done;

  modport master (
    output pad_yy_test_mode,
    output cp0_clk_lpmd_req,
    output cp0_clk_lpmd_mode,
    output core_clk_idle,
    output pad_clk_wakeup,
    output had_clk_dbg_req,
    input  clk_core_gate_en,
    input  clk_cp0_lpmd_ack,
    input  clk_pad_lpmd_b,
    input  clk_cp0_wakeup_done
  );

  modport slave (
    input  pad_yy_test_mode,
    input  cp0_clk_lpmd_req,
    input  cp0_clk_lpmd_mode,
    input  core_clk_idle,
    input  pad_clk_wakeup,
    input  had_clk_dbg_req,
    output clk_core_gate_en,
    output clk_cp0_lpmd_ack,
    output clk_pad_lpmd_b,
    output clk_cp0_wakeup_done
  );
endinterface

// File: rtl/cr_clk_lpmd_ctrl.sv
// Core clock low-power sequencer: drain, settle, gate, wake, ack.
// Ports: forever_cpuclk, cpurst_b (async low), bus (lpmd handshake, slave).
// Option: CLK_LPMD_DBG_WAKE_EN makes had_clk_dbg_req a wakeup source.
module cr_clk_lpmd_ctrl #(
  parameter int GATE_DLY = 4,
  parameter int WAKE_DLY = 8,
  parameter int CNT_W    = 4
) (
  input logic               forever_cpuclk,
  input logic               cpurst_b,
  cr_clk_lpmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_SETTLE,
    S_SLEEP,
    S_WAKE
  } state_t;

  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_DLY - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_DLY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             gate_q;
  logic             ack_q;
  logic             done_q;
  logic [1:0]       lpmd_q;
  logic             req_seen;
  logic             wake;
  logic             new_req;

`ifdef CLK_LPMD_DBG_WAKE_EN
  assign wake = bus.pad_clk_wakeup | bus.had_clk_dbg_req;
`else
  logic unused_dbg;
  assign unused_dbg = bus.had_clk_dbg_req;
  assign wake = bus.pad_clk_wakeup;
`endif

  // A held request only counts again after req has been seen low.
  assign new_req = bus.cp0_clk_lpmd_req & ~req_seen;
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= S_IDLE;
      cnt      <= '0;
      gate_q   <= 1'b1;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      lpmd_q   <= 2'b11;
      req_seen <= 1'b0;
    end else begin
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      req_seen <= bus.cp0_clk_lpmd_req & req_seen;
      if (bus.pad_yy_test_mode) begin
        state  <= S_IDLE;
        cnt    <= '0;
        gate_q <= 1'b1;
        lpmd_q <= 2'b11;
      end else begin
        unique case (state)
          S_IDLE: begin
            // Pending wakeup suppresses entry entirely.
            if (!wake && new_req) begin
              req_seen <= 1'b1;
              if (bus.cp0_clk_lpmd_mode == 2'b11) begin
                ack_q <= 1'b1;
              end else begin
                lpmd_q <= bus.cp0_clk_lpmd_mode;
                state  <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (wake) begin
              lpmd_q <= 2'b11;
              ack_q  <= 1'b1;
              state  <= S_IDLE;
            end else if (bus.core_clk_idle) begin
              cnt   <= '0;
              state <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (wake) begin
              cnt   <= '0;
              state <= S_WAKE;
            end else if (cnt == GATE_LAST) begin
              gate_q <= 1'b0;
              state  <= S_SLEEP;
            end else begin
              cnt <= cnt_inc;
            end
          end
          S_SLEEP: begin
            if (wake) begin
              gate_q <= 1'b1;
              cnt    <= '0;
              state  <= S_WAKE;
            end
          end
          S_WAKE: begin
            // Runs to completion even if wakeup drops.
            if (cnt == WAKE_LAST) begin
              done_q <= 1'b1;
              ack_q  <= 1'b1;
              lpmd_q <= 2'b11;
              cnt    <= '0;
              state  <= S_IDLE;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.clk_core_gate_en    = gate_q | bus.pad_yy_test_mode;
  assign bus.clk_cp0_lpmd_ack    = ack_q;
  assign bus.clk_pad_lpmd_b      = lpmd_q;
  assign bus.clk_cp0_wakeup_done = done_q;

endmodule

// File: tb/tb_cr_clk_lpmd_ctrl.sv
// Testbench for cr_clk_lpmd_ctrl: table vectors, corner sequences, random.
// Outputs compared as {gate_en, ack, lpmd_b, wakeup_done}.
module tb_cr_clk_lpmd_ctrl;

  localparam int GD = 4;
  localparam int WD = 8;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nerr;

  cr_clk_lpmd_ctrl_if bus();

  cr_clk_lpmd_ctrl #(
    .GATE_DLY(GD),
    .WAKE_DLY(WD),
    .CNT_W(4)
  ) dut (
    .forever_cpuclk(clk),
    .cpurst_b(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       req;
    logic [1:0] mode;
    logic       idle;
    logic       wake;
    logic       tm;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [4:0] ex(input logic g, input logic a,
                                    input logic [1:0] l, input logic d);
    return {g, a, l, d};
  endfunction

  function automatic void add(input int n, input logic r,
                              input logic [1:0] m, input logic i,
                              input logic w, input logic t,
                              input logic g, input logic a,
                              input logic [1:0] l, input logic d);
    vec_t v;
    v.req  = r;
    v.mode = m;
    v.idle = i;
    v.wake = w;
    v.tm   = t;
    v.exp  = ex(g, a, l, d);
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  function automatic logic [4:0] outs();
    return {bus.clk_core_gate_en, bus.clk_cp0_lpmd_ack,
            bus.clk_pad_lpmd_b, bus.clk_cp0_wakeup_done};
  endfunction

  task automatic check(input string name, input logic [4:0] act,
                       input logic [4:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (gate,ack,lpmd_b,done)",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [1:0] m,
                       input logic i, input logic w,
                       input logic dbg, input logic t);
    bus.cp0_clk_lpmd_req  = r;
    bus.cp0_clk_lpmd_mode = m;
    bus.core_clk_idle     = i;
    bus.pad_clk_wakeup    = w;
    bus.had_clk_dbg_req   = dbg;
    bus.pad_yy_test_mode  = t;
  endtask

  task automatic cyc(input string name, input logic r,
                     input logic [1:0] m, input logic i,
                     input logic w, input logic dbg, input logic t,
                     input logic [4:0] exp);
    drive(r, m, i, w, dbg, t);
    @(posedge clk);
    #1;
    check(name, outs(), exp);
  endtask

  task automatic goto_sleep(input logic [1:0] m);
    cyc("enter", 1'b1, m, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, m, 0));
    repeat (GD)
      cyc("settle", 1'b1, m, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, m, 0));
    cyc("gate_off", 1'b1, m, 1'b1, 1'b0, 1'b0, 1'b0, ex(0, 0, m, 0));
  endtask

  task automatic quiet(input int n);
    repeat (n)
      cyc("quiet", 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, ex(1, 0, 3, 0));
  endtask

  // Reference: outcome of one request computed from event times.
  task automatic rand_txn();
    logic [1:0] m;
    int d, w, len, t;
    int ack_e, done_e, goff, gon, lp_end;
    m      = 2'($urandom_range(0, 3));
    d      = $urandom_range(1, 6);
    w      = $urandom_range(1, 22);
    len    = $urandom_range(1, 3);
    ack_e  = -1;
    done_e = -1;
    goff   = -1;
    gon    = -1;
    lp_end = 0;
    if (m == 2'b11) begin
      ack_e = 0;
    end else if (w <= d) begin
      ack_e  = w;
      lp_end = w;
    end else begin
      if (w > d + GD) begin
        goff = d + GD;
        gon  = w;
      end
      done_e = w + WD;
      ack_e  = done_e;
      lp_end = done_e;
    end
    t = w + len;
    if (done_e + 1 > t) t = done_e + 1;
    t = t + 2;
    for (int k = 0; k < t; k++) begin
      logic [1:0] mi;
      logic g, a, dn;
      logic [1:0] l;
      mi = (k == 0) ? m : 2'($urandom_range(0, 3));
      g  = !(goff >= 0 && k >= goff && k < gon);
      a  = (k == ack_e);
      dn = (k == done_e);
      l  = (m != 2'b11 && k < lp_end) ? m : 2'b11;
      cyc("rand", 1'b1, mi, (k >= d), (k >= w && k < w + len),
          1'b0, 1'b0, ex(g, a, l, dn));
    end
    quiet(2);
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", outs(), ex(1, 0, 3, 0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_gate", {4'b0, bus.clk_core_gate_en}, 5'b00001);
    check("rst_ack", {4'b0, bus.clk_cp0_lpmd_ack}, 5'b00000);
    check("rst_lpmd", {3'b0, bus.clk_pad_lpmd_b}, 5'b00011);
    check("rst_done", {4'b0, bus.clk_cp0_wakeup_done}, 5'b00000);

    // wait mode: drain 3 cycles, gate, wake, complete
    add(3, 1, 2, 0, 0, 0, 1, 0, 2, 0);
    add(4, 1, 2, 1, 0, 0, 1, 0, 2, 0);
    add(2, 1, 2, 1, 0, 0, 0, 0, 2, 0);
    add(1, 1, 2, 1, 1, 0, 1, 0, 2, 0);
    add(7, 1, 2, 1, 0, 0, 1, 0, 2, 0);
    add(1, 1, 2, 1, 0, 0, 1, 1, 3, 1);
    add(1, 0, 2, 0, 0, 0, 1, 0, 3, 0);
    // mode none: single ack, held req ignored, new edge acks again
    add(1, 1, 3, 0, 0, 0, 1, 1, 3, 0);
    add(2, 1, 3, 0, 0, 0, 1, 0, 3, 0);
    add(1, 0, 3, 0, 0, 0, 1, 0, 3, 0);
    add(1, 1, 3, 0, 0, 0, 1, 1, 3, 0);
    add(1, 0, 3, 0, 0, 0, 1, 0, 3, 0);
    // test mode while asleep
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(4, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 1, 0, 3, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 3, 0);
    // wakeup beats req in idle; wakeup aborts drain
    add(1, 1, 1, 0, 1, 0, 1, 0, 3, 0);
    add(1, 1, 1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 1, 1, 0, 1, 0, 1, 1, 3, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 3, 0);
    // wakeup in settle: gate never drops, full wake delay
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(2, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 1, 0, 0, 0);
    add(7, 1, 0, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 1, 1, 3, 1);
    add(1, 0, 0, 0, 0, 0, 1, 0, 3, 0);

    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("tbl%0d", i), tbl[i].req, tbl[i].mode,
          tbl[i].idle, tbl[i].wake, 1'b0, tbl[i].tm, tbl[i].exp);

    // test mode forces gate enable without a clock edge
    goto_sleep(2'b00);
    bus.pad_yy_test_mode = 1'b1;
    #1;
    check("tm_comb", outs(), ex(1, 0, 0, 0));
    @(posedge clk);
    #1;
    check("tm_idle", outs(), ex(1, 0, 3, 0));
    quiet(2);

    // asynchronous reset while asleep
    goto_sleep(2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), ex(1, 0, 3, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet(2);

    // debug request while asleep
    goto_sleep(2'b10);
`ifdef CLK_LPMD_DBG_WAKE_EN
    cyc("dbg_wake", 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, ex(1, 0, 2, 0));
    repeat (WD - 1)
      cyc("dbg_run", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, 2, 0));
    cyc("dbg_done", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 1, 3, 1));
`else
    repeat (3)
      cyc("dbg_sleep", 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, ex(0, 0, 2, 0));
    cyc("pad_wake", 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, ex(1, 0, 2, 0));
    repeat (WD - 1)
      cyc("pad_run", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 0, 2, 0));
    cyc("pad_done", 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, ex(1, 1, 3, 1));
`endif
    quiet(2);

    repeat (60) rand_txn();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
